bcd_scan_mux: RTL and testbench
===============================

Name: bcd_scan_mux

Overview:
- Upstream feeder for the deco7seg segment decoder: holds a NUM_DIGITS-wide packed BCD word and time-multiplexes one digit at a time onto the decoder's 4-bit BCD inputs (a_o..d_o map to decoder ai..di).
- Drives active-low digit anodes so that a single decoder serves a multi-digit display.
- Provides tear-free frame-synchronous digit loading with a load/ack handshake and per-slot dead time against ghosting.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles per digit slot (>= DEAD+2).
- PRESCALE_W, 16, prescaler counter width; must hold PRESCALE-1.
- DEAD, 2, cycles at the start of each slot during which all anodes are off.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  scan enable.
- digits_i  input  4*NUM_DIGITS  packed BCD; digit k = bits [4k+3:4k]; digit 0 is least significant.
- load_i  input  1  request to capture digits_i.
- ack_o  output  1  one-cycle pulse when the captured value becomes displayed.
- a_o  output  1  BCD bit 3 (MSB) to decoder ai.
- b_o  output  1  BCD bit 2 to decoder bi.
- c_o  output  1  BCD bit 1 to decoder ci.
- d_o  output  1  BCD bit 0 (LSB) to decoder di.
- anode_n_o  output  NUM_DIGITS  active-low digit enables, one-hot-low or all high.
- frame_o  output  1  one-cycle pulse on each frame wrap.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low. All state changes occur on rising clk edges only.
- Reset values:
  - Prescaler = 0, slot index = 0.
  - Staging, shadow, pending = 0.
  - a_o..d_o = 0, anode_n_o = all 1, ack_o = 0, frame_o = 0.
- Reset asserted mid-operation aborts any pending load without an ack.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1, then wraps to 0.
  - A wrap is a tick. On a tick, the slot index advances modulo NUM_DIGITS.
  - A tick with index NUM_DIGITS-1 → 0 is a frame wrap; frame_o pulses in the cycle after that edge.
- en=0: prescaler and index hold their values, anode_n_o = all 1, a_o..d_o hold, and frame wraps cannot occur. On re-enable, counting resumes from the held count.
- Load handshake:
  - load_i=1 writes digits_i into staging and sets pending. Any number of loads before a frame wrap is allowed; the last one wins.
  - At a frame-wrap edge with pending=1: shadow ← staging, pending ← 0, ack_o=1 for the next cycle only.
  - load_i on the frame-wrap cycle itself: digits_i goes directly into shadow at that edge, pending ← 0, and ack_o pulses.
  - ack_o never pulses without a prior load.
- Outputs:
  - Registered with one cycle of latency from the current (index, prescaler) state.
  - a_o..d_o = shadow digit[index], updated in the cycle after each tick.
  - anode_n_o[index] = 0 when all of the following hold: en=1, prescaler >= DEAD, and shadow digit[index] <= 9. Otherwise all bits = 1.
  - A digit value of 10..15 blanks its slot; the invalid code is still presented on a_o..d_o.
- Only one anode bit may be low at a time, in every cycle.

Optional Feature:
- Macro: BCD_SCAN_LZ_BLANK_EN.
- Defined: leading-zero suppression. In the slot for digit k>0, the anode stays off when digit k and every more-significant digit equal 0. Digit 0 is never suppressed. Evaluation uses shadow, not staging.
- Undefined: every digit <=9 is shown, including leading zeros.

Test Plan:
- Bench settings for all scenarios: NUM_DIGITS=4, PRESCALE=4, DEAD=1.
- Reset: hold rst_n=0 for 3 cycles with en=1 → anode_n_o=4'b1111, a_o..d_o=0, ack_o=0. Release → first anode low (4'b1110) appears at cycle 2 of slot 0.
- Scan order: load 16'h1234 then run 2 frames → ack_o pulses once at the first frame wrap. Sequence per slot: a_o..d_o = 4,3,2,1 with anode_n_o = 1110, 1101, 1011, 0111, each low for 3 of 4 cycles.
- Last-wins and simultaneous load: load 16'h1111 then 16'h9876 within one frame → single ack, 9876 displayed. Then assert load_i with 16'h0005 exactly on a frame-wrap cycle → ack next cycle, 0005 shown from the next frame.
- Blanking: load 16'hA0F3 → slots 0 and 2 show 3 and 0. Slots 1 and 3 keep anode_n_o=1111 while a_o..d_o = 4'hF and 4'hA respectively.
- Enable: drop en mid-slot 2 for 10 cycles → anode_n_o=1111, index and prescaler frozen, no frame_o. Raise en → slot 2 completes its remaining cycles.
- Macro: with BCD_SCAN_LZ_BLANK_EN defined, load 16'h0070 → only slots 0 and 1 light (0 and 7); slots 2 and 3 stay 1111. Without the macro, all four slots light.

Source files
------------

// File: rtl/bcd_scan_mux.sv
// BCD scan multiplexer: time-multiplexes a packed BCD word onto one
// 7-segment decoder, one digit per slot, with active-low digit anodes.
// Ports: clk, rst_n (sync, active-low), en (scan enable),
//   digits_i/load_i (staged load), ack_o (load displayed),
//   a_o..d_o (BCD MSB..LSB), anode_n_o (active-low), frame_o (wrap pulse).
// Optional: define BCD_SCAN_LZ_BLANK_EN for leading-zero suppression.
module bcd_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int PRESCALE_W = 16,
  parameter int DEAD       = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
  output logic                    ack_o,
  output logic                    a_o,
  output logic                    b_o,
  output logic                    c_o,
  output logic                    d_o,
  output logic [NUM_DIGITS-1:0]   anode_n_o,
  output logic                    frame_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;

  logic [PRESCALE_W-1:0] cnt;
  logic [IDX_W-1:0]      idx;
  logic [DW-1:0]         staging;
  logic [DW-1:0]         shadow;
  logic                  pending;

  logic [3:0]            bcd_q;
  logic [NUM_DIGITS-1:0] anode_q;
  logic                  ack_q;
  logic                  frame_q;

  logic                  tick;
  logic                  wrap;
  logic                  commit;
  logic [3:0]            cur;
  logic                  sup;
  logic                  light;
  logic [NUM_DIGITS-1:0] anode_d;

  always_comb begin
    tick   = en && (cnt == PRESCALE_W'(PRESCALE - 1));
    wrap   = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    commit = wrap && (pending || load_i);
  end

  // Digit for the current slot, selected from the displayed shadow.
  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) cur = shadow[4*k +: 4];
    end
  end

`ifdef BCD_SCAN_LZ_BLANK_EN
  // A slot k>0 is a leading zero when it and all higher digits are 0.
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run   = run && (shadow[4*k +: 4] == 4'd0);
      lz[k] = run && (k != 0);
    end
  end

  always_comb begin
    sup = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) sup = lz[k];
    end
  end
`else
  always_comb sup = 1'b0;
`endif

  // Anode lit only past the dead time, for a valid, unsuppressed digit.
  always_comb begin
    light   = en && (cnt >= PRESCALE_W'(DEAD)) &&
              (cur <= 4'd9) && !sup;
    anode_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (light && (idx == IDX_W'(k))) anode_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (tick) begin
        cnt <= '0;
        idx <= wrap ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + PRESCALE_W'(1);
      end
    end
  end

  // A load on the wrap cycle bypasses staging straight into shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staging <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (load_i) begin
        staging <= digits_i;
        pending <= 1'b1;
      end
      if (commit) begin
        shadow  <= load_i ? digits_i : staging;
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      anode_q <= '1;
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      if (en) bcd_q <= cur;
      anode_q <= anode_d;
      ack_q   <= commit;
      frame_q <= wrap;
    end
  end

  assign a_o       = bcd_q[3];
  assign b_o       = bcd_q[2];
  assign c_o       = bcd_q[1];
  assign d_o       = bcd_q[0];
  assign anode_n_o = anode_q;
  assign ack_o     = ack_q;
  assign frame_o   = frame_q;

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux (NUM_DIGITS=4, PRESCALE=4, DEAD=1).
// Vector table of loads with hand-computed per-slot anode patterns.
module tb_bcd_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic        load;
  logic        ack;
  logic        a, b, c, d;
  logic [3:0]  anode_n;
  logic        frame;

  int tests = 0;
  int fails = 0;

  bcd_scan_mux #(
    .NUM_DIGITS(4),
    .PRESCALE(4),
    .PRESCALE_W(16),
    .DEAD(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .digits_i(digits),
    .load_i(load),
    .ack_o(ack),
    .a_o(a),
    .b_o(b),
    .c_o(c),
    .d_o(d),
    .anode_n_o(anode_n),
    .frame_o(frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        on_wrap;
    logic        pre_en;
    logic [15:0] pre;
    logic [15:0] word;
    logic [15:0] an_exp;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks one full frame starting right after a frame_o pulse.
  task automatic check_frame(string name, logic [15:0] bcd_exp,
                             logic [15:0] an_exp);
    for (int k = 0; k < 16; k++) begin
      int s;
      int j;
      logic [3:0] ea;
      step();
      s  = k / 4;
      j  = k % 4;
      ea = (j == 0) ? 4'hF : an_exp[s*4 +: 4];
      check($sformatf("%s slot%0d cyc%0d", name, s, j),
            {a, b, c, d, anode_n}, {bcd_exp[s*4 +: 4], ea});
      check($sformatf("%s ack%0d", name, k), {7'd0, ack}, 8'd0);
      check($sformatf("%s frame%0d", name, k), {7'd0, frame},
            {7'd0, (k == 15)});
    end
  endtask

  task automatic wait_ack(string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (ack) seen = 1'b1;
    end
    check({name, " ack seen"}, {7'd0, seen}, 8'd1);
    check({name, " ack with frame"}, {7'd0, frame}, 8'd1);
  endtask

  logic [3:0] en_an[6];
  logic [3:0] en_bcd[6];

  initial begin
    tbl[0] = '{"scan1234", 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h7BDE};
    tbl[1] = '{"lastwin", 1'b0, 1'b1, 16'h1111, 16'h9876, 16'h7BDE};
    tbl[2] = '{"blankA0F3", 1'b0, 1'b0, 16'h0000, 16'hA0F3, 16'hFBFE};
`ifdef BCD_SCAN_LZ_BLANK_EN
    tbl[3] = '{"lz0070", 1'b0, 1'b0, 16'h0000, 16'h0070, 16'hFFDE};
    tbl[4] = '{"wrap0005", 1'b1, 1'b0, 16'h0000, 16'h0005, 16'hFFFE};
`else
    tbl[3] = '{"lz0070", 1'b0, 1'b0, 16'h0000, 16'h0070, 16'h7BDE};
    tbl[4] = '{"wrap0005", 1'b1, 1'b0, 16'h0000, 16'h0005, 16'h7BDE};
`endif
    tbl[5] = '{"scan4321", 1'b0, 1'b0, 16'h0000, 16'h4321, 16'h7BDE};

    en_an  = '{4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    en_bcd = '{4'h3, 4'h3, 4'h4, 4'h4, 4'h4, 4'h4};

    rst_n  = 1'b0;
    en     = 1'b1;
    load   = 1'b0;
    digits = 16'h0000;
    repeat (3) step();
    check("reset out", {a, b, c, d, anode_n}, {4'h0, 4'hF});
    check("reset pulses", {6'd0, ack, frame}, 8'd0);

    rst_n = 1'b1;
    step();
    check("rel cyc1", {a, b, c, d, anode_n}, {4'h0, 4'hF});
    step();
    check("rel cyc2", {a, b, c, d, anode_n}, {4'h0, 4'hE});

    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        step();
        if (frame) seen = 1'b1;
      end
      check("first frame", {7'd0, seen}, 8'd1);
      check("no ack unloaded", {7'd0, ack}, 8'd0);
    end

    for (int v = 0; v < 6; v++) begin
      if (tbl[v].on_wrap) begin
        for (int i = 0; i < 15; i++) begin
          step();
          check({tbl[v].name, " pre ack"}, {7'd0, ack}, 8'd0);
        end
        load   = 1'b1;
        digits = tbl[v].word;
        step();
        load   = 1'b0;
        check({tbl[v].name, " ack"}, {6'd0, ack, frame}, 8'd3);
      end else begin
        if (tbl[v].pre_en) begin
          load   = 1'b1;
          digits = tbl[v].pre;
          step();
        end
        load   = 1'b1;
        digits = tbl[v].word;
        step();
        load   = 1'b0;
        digits = 16'hDEAD;
        wait_ack(tbl[v].name);
      end
      check_frame(tbl[v].name, tbl[v].word, tbl[v].an_exp);
    end

    repeat (10) step();
    check("en pre", {a, b, c, d, anode_n}, {4'h3, 4'hB});
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("en off %0d", i), {a, b, c, d, anode_n},
            {4'h3, 4'hF});
      check($sformatf("en off frame %0d", i), {7'd0, frame}, 8'd0);
    end
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("en resume %0d", i), {a, b, c, d, anode_n},
            {en_bcd[i], en_an[i]});
      check($sformatf("en frame %0d", i), {7'd0, frame},
            {7'd0, (i == 5)});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
